// File: rtl/vga_sync_generator.sv
// Vertical timing for the 25 MHz VGA chain: owns the line counter and vertical phase,
// and registers sync, blanking, pixel coordinates and frame-start for the pixel pipeline.
module vga_sync_generator #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        enable_V_counter,
    input  logic [15:0] H_Count_Value,
    output logic [15:0] V_Count_Value,
    output logic        h_sync,
    output logic        v_sync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        frame_start
);

    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_ACT_END    = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_ACT_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] V_FP_LAST    = 16'(V_ACTIVE + V_FP - 1);
    localparam logic [15:0] V_SYNC_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } vstate_t;

    vstate_t     state_q, state_d;
    logic [15:0] v_count_q, v_count_d;
    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;
    logic        video_on_q, video_on_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic [9:0]  pixel_y_q, pixel_y_d;
    logic        frame_start_q, frame_start_d;
    logic        h_sync_active;

    // Counter and phase move together so the phase always describes v_count_q.
    always_comb begin
        v_count_d = v_count_q;
        state_d   = state_q;
        if (enable_V_counter) begin
            v_count_d = (v_count_q == V_LAST) ? 16'd0 : v_count_q + 16'd1;
            case (state_q)
                ST_ACTIVE: if (v_count_q == V_ACT_LAST)  state_d = ST_FRONT;
                ST_FRONT:  if (v_count_q == V_FP_LAST)   state_d = ST_SYNC;
                ST_SYNC:   if (v_count_q == V_SYNC_LAST) state_d = ST_BACK;
                ST_BACK:   if (v_count_q == V_LAST)      state_d = ST_ACTIVE;
                default:                                 state_d = ST_ACTIVE;
            endcase
        end
    end

    // Outputs use the line held before this edge's update, with full-width h compares.
    always_comb begin
        h_sync_active = (H_Count_Value >= H_SYNC_START) && (H_Count_Value < H_SYNC_END);
        h_sync_d      = h_sync_active ? SYNC_POL : ~SYNC_POL;
        v_sync_d      = (state_q == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (H_Count_Value < H_ACT_END) && (state_q == ST_ACTIVE);
        pixel_x_d     = video_on_d ? H_Count_Value[9:0] : 10'd0;
        pixel_y_d     = video_on_d ? v_count_q[9:0] : 10'd0;
        frame_start_d = enable_V_counter && (v_count_q == V_LAST);
    end

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ACTIVE;
            v_count_q     <= 16'd0;
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= 10'd0;
            pixel_y_q     <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            v_count_q     <= v_count_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign V_Count_Value = v_count_q;
    assign h_sync        = h_sync_q;
    assign v_sync        = v_sync_q;
    assign video_on      = video_on_q;
    assign pixel_x       = pixel_x_q;
    assign pixel_y       = pixel_y_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: range-based timing model checked every cycle against
// an active-low and an active-high build, plus literal checkpoints along the frame.
module tb_vga_sync_generator;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] hval;

    logic [15:0] v0, v1;
    logic        hs0, vs0, vid0, fs0, hs1, vs1, vid1, fs1;
    logic [9:0]  px0, py0, px1, py1;

    vga_sync_generator #(.SYNC_POL(1'b0)) dut0 (
        .clk_25MHz(clk), .reset(reset), .enable_V_counter(en), .H_Count_Value(hval),
        .V_Count_Value(v0), .h_sync(hs0), .v_sync(vs0), .video_on(vid0),
        .pixel_x(px0), .pixel_y(py0), .frame_start(fs0)
    );

    vga_sync_generator #(.SYNC_POL(1'b1)) dut1 (
        .clk_25MHz(clk), .reset(reset), .enable_V_counter(en), .H_Count_Value(hval),
        .V_Count_Value(v1), .h_sync(hs1), .v_sync(vs1), .video_on(vid1),
        .pixel_x(px1), .pixel_y(py1), .frame_start(fs1)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the current line number plus the output values the timing rules imply.
    int m_line  = 0;
    bit e_hs    = 0;
    bit e_vs    = 0;
    bit e_vid   = 0;
    int e_px    = 0;
    int e_py    = 0;
    bit e_fs    = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_line <= 0;
            e_hs   <= 0;
            e_vs   <= 0;
            e_vid  <= 0;
            e_px   <= 0;
            e_py   <= 0;
            e_fs   <= 0;
        end else begin
            e_hs   <= (int'(hval) >= 656) && (int'(hval) <= 751);
            e_vs   <= (m_line == 490) || (m_line == 491);
            e_vid  <= (int'(hval) < 640) && (m_line < 480);
            e_px   <= ((int'(hval) < 640) && (m_line < 480)) ? int'(hval) : 0;
            e_py   <= ((int'(hval) < 640) && (m_line < 480)) ? m_line : 0;
            e_fs   <= en && (m_line == 524);
            m_line <= en ? ((m_line + 1) % 525) : m_line;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("vcount", int'(v0), m_line);
            chk("hsync_lo", int'(hs0), e_hs ? 0 : 1);
            chk("vsync_lo", int'(vs0), e_vs ? 0 : 1);
            chk("video", int'(vid0), int'(e_vid));
            chk("pixel_x", int'(px0), e_px);
            chk("pixel_y", int'(py0), e_py);
            chk("frame_start", int'(fs0), int'(e_fs));
            chk("vcount_hi", int'(v1), m_line);
            chk("hsync_hi", int'(hs1), e_hs ? 1 : 0);
            chk("vsync_hi", int'(vs1), e_vs ? 1 : 0);
            chk("video_hi", int'(vid1), int'(e_vid));
            chk("frame_start_hi", int'(fs1), int'(e_fs));
        end
    end

    task automatic step(input bit e, input logic [15:0] h);
        @(negedge clk);
        en   = e;
        hval = h;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_h();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel < 2)       rand_h = 16'($urandom_range(0, 799));
        else if (sel == 2) rand_h = 16'($urandom_range(630, 760));
        else               rand_h = 16'($urandom);
    endfunction

    task automatic run_line();
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) step(1'b0, rand_h());
        step(1'b1, rand_h());
    endtask

    int pulses = 0;

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        hval  = 16'd0;
        #2 reset = 1'b1;
        #1;
        chk("rst_vcount", int'(v0), 0);
        chk("rst_hsync", int'(hs0), 1);
        chk("rst_vsync", int'(vs0), 1);
        chk("rst_hsync_hi", int'(hs1), 0);
        chk("rst_video", int'(vid0), 0);
        chk("rst_fs", int'(fs0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        run   = 1;

        // Sweep one line with no enable pulses.
        for (int h = 0; h < 800; h++) begin
            step(1'b0, 16'(h));
            if (h == 0)   chk("sweep_x0_video", int'(vid0), 1);
            if (h == 639) chk("sweep_x639", int'(px0), 639);
            if (h == 640) chk("sweep_x640_video", int'(vid0), 0);
            if (h == 655) chk("sweep_h655", int'(hs0), 1);
            if (h == 656) chk("sweep_h656", int'(hs0), 0);
            if (h == 751) chk("sweep_h751", int'(hs0), 0);
            if (h == 752) chk("sweep_h752", int'(hs0), 1);
        end
        chk("sweep_vcount", int'(v0), 0);
        $display("sweep of line 0 done");

        // Full frame and then up to line 300 of the next one.
        for (int k = 1; k <= 825; k++) begin
            if (m_line == 10 && k == 11) begin
                step(1'b0, 16'd800);
                chk("l10_h800_hs", int'(hs0), 1);
                chk("l10_h800_vid", int'(vid0), 0);
                chk("l10_h800_px", int'(px0), 0);
                step(1'b0, 16'hFFFF);
                chk("l10_hffff_hs", int'(hs0), 1);
                chk("l10_hffff_vid", int'(vid0), 0);
                chk("l10_hffff_px", int'(px0), 0);
                step(1'b0, 16'd100);
                chk("l10_px", int'(px0), 100);
                chk("l10_py", int'(py0), 10);
            end
            run_line();
            pulses++;
            $display("pulse %0d: line now %0d", pulses, v0);
            if (k == 490) begin
                chk("p490_vcount", int'(v0), 490);
                step(1'b0, 16'd100);
                chk("p490_vsync", int'(vs0), 0);
                chk("p490_video", int'(vid0), 0);
                chk("p490_px", int'(px0), 0);
            end
            if (k == 491) begin
                step(1'b0, 16'd660);
                chk("p491_vsync_hi", int'(vs1), 1);
                chk("p491_hsync_hi", int'(hs1), 1);
            end
            if (k == 492) begin
                step(1'b0, 16'd100);
                chk("p492_vsync", int'(vs0), 1);
            end
            if (k == 525) begin
                chk("p525_vcount", int'(v0), 0);
                chk("p525_fs", int'(fs0), 1);
                step(1'b0, 16'd5);
                chk("p525_fs_next", int'(fs0), 0);
                chk("p525_px", int'(px0), 5);
            end
        end
        chk("line300", int'(v0), 300);

        // Asynchronous reset mid-line, then an enable held through reset.
        step(1'b0, 16'd700);
        #5 reset = 1'b1;
        #1;
        chk("async_hs", int'(hs0), 1);
        chk("async_vs", int'(vs0), 1);
        chk("async_vid", int'(vid0), 0);
        chk("async_vcount", int'(v0), 0);
        step(1'b1, 16'd10);
        chk("rst_en_vcount", int'(v0), 0);
        chk("rst_en_fs", int'(fs0), 0);
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b0;
        step(1'b1, 16'd20);
        chk("post_rst_vcount", int'(v0), 1);
        for (int k = 0; k < 40; k++) begin
            run_line();
            $display("post-reset pulse: line now %0d", v0);
        end
        step(1'b0, 16'd0);
        @(negedge clk);
        run = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
